// File: rtl/nap_ds_arb_pkg.sv
// Shared types and helpers for the NAP data-stream transmit arbiter.
package nap_ds_arb_pkg;
  localparam int MAX_REQ = 8;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // First set bit of req at or above ptr, wrapping at n-1 back to 0.
  function automatic rr_pick_t rr_find_first(input logic [MAX_REQ-1:0] req,
                                             input logic [2:0] ptr,
                                             input int unsigned n);
    rr_pick_t    p;
    int unsigned k;
    p = '0;
    for (int i = MAX_REQ-1; i >= 0; i--) begin
      if (i < n) begin
        k = 32'(ptr) + i;
        if (k >= n) k = k - n;
        if (req[k[2:0]]) begin
          p.found = 1'b1;
          p.idx   = k[2:0];
        end
      end
    end
    return p;
  endfunction
endpackage

// File: rtl/t_data_stream.sv
// NAP data-stream interface: one beat of data/addr with sop/eop framing.
interface t_DATA_STREAM #(parameter int DATA_WIDTH = 256, parameter int ADDR_WIDTH = 4);
  logic                  valid;
  logic                  ready;
  logic                  sop;
  logic                  eop;
  logic [DATA_WIDTH-1:0] data;
  logic [ADDR_WIDTH-1:0] addr;
  modport tx (output valid, sop, eop, data, addr, input ready);
  modport rx (input valid, sop, eop, data, addr, output ready);
endinterface

// File: rtl/nap_ds_skid_buf.sv
// Two-entry skid buffer: registers the beat and the upstream ready while
// keeping one beat per cycle when the sink is always ready.
module nap_ds_skid_buf #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_valid,
  input  logic                  i_sop,
  input  logic                  i_eop,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  o_ready,
  output logic                  o_valid,
  output logic                  o_sop,
  output logic                  o_eop,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [ADDR_WIDTH-1:0] o_addr,
  input  logic                  i_ready
);
  localparam int BW = DATA_WIDTH + ADDR_WIDTH + 2;

  logic [BW-1:0] out_q, skid_q, in_beat;
  logic          out_vld_q, skid_vld_q;

  assign in_beat = {i_sop, i_eop, i_addr, i_data};
  assign o_ready = !skid_vld_q;
  assign {o_sop, o_eop, o_addr, o_data} = out_q;
  assign o_valid = out_vld_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
    end else if (!out_vld_q || i_ready) begin
      // Output slot frees up: drain the skid entry first to keep order.
      if (skid_vld_q) begin
        out_q      <= skid_q;
        out_vld_q  <= 1'b1;
        skid_vld_q <= 1'b0;
      end else begin
        out_vld_q <= i_valid;
        if (i_valid) out_q <= in_beat;
      end
    end else if (i_valid && !skid_vld_q) begin
      skid_q     <= in_beat;
      skid_vld_q <= 1'b1;
    end
  end
endmodule

// File: rtl/nap_ds_tx_arbiter.sv
// Packet-aware round-robin arbiter onto one NAP transmit stream.
// Define NAP_DS_ARB_OUTREG_EN to insert a registered skid buffer at the output.
module nap_ds_tx_arbiter
  import nap_ds_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic [N_REQ-1:0]            i_req_valid,
  input  logic [N_REQ-1:0]            i_req_sop,
  input  logic [N_REQ-1:0]            i_req_eop,
  input  logic [N_REQ*DATA_WIDTH-1:0] i_req_data,
  input  logic [N_REQ*ADDR_WIDTH-1:0] i_req_addr,
  output logic [N_REQ-1:0]            o_req_ready,
  t_DATA_STREAM.tx                    if_ds_tx,
  output logic [N_REQ-1:0]            o_grant,
  output logic                        o_drop
);
  arb_state_t            state_q, state_d;
  logic [2:0]            ptr_q, ptr_d, owner_q, owner_d, sel;
  logic [MAX_REQ-1:0]    elig;
  rr_pick_t              pick;
  logic                  sel_en, drop, acc;
  logic [N_REQ-1:0]      gnt_oh, drop_oh;
  logic                  a_valid, a_ready, a_sop, a_eop;
  logic [DATA_WIDTH-1:0] a_data;
  logic [ADDR_WIDTH-1:0] a_addr;

  function automatic logic [2:0] inc_wrap(input logic [2:0] x);
    return (x == 3'(N_REQ-1)) ? 3'd0 : x + 3'd1;
  endfunction

  always_comb begin
    elig             = '0;
    elig[N_REQ-1:0]  = i_req_valid & i_req_sop;
    pick             = rr_find_first(elig, ptr_q, N_REQ);
    sel_en           = (state_q == ARB_LOCKED) || pick.found;
    sel              = (state_q == ARB_LOCKED) ? owner_q : pick.idx;
    a_data           = '0;
    a_addr           = '0;
    for (int r = 0; r < N_REQ; r++) begin
      gnt_oh[r] = sel_en && (sel == 3'(r));
      if (gnt_oh[r]) begin
        a_data = i_req_data[r*DATA_WIDTH +: DATA_WIDTH];
        a_addr = i_req_addr[r*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
    a_valid = |(gnt_oh & i_req_valid);
    a_sop   = |(gnt_oh & i_req_sop);
    a_eop   = |(gnt_oh & i_req_eop);
    acc     = a_valid && a_ready;

    // Stray non-SOP beats are only flushed when nobody can be granted.
    drop    = 1'b0;
    drop_oh = '0;
    if (state_q == ARB_IDLE && !pick.found) begin
      for (int r = N_REQ-1; r >= 0; r--) begin
        if (i_req_valid[r] && !i_req_sop[r]) begin
          drop_oh    = '0;
          drop_oh[r] = 1'b1;
          drop       = 1'b1;
        end
      end
    end

    o_grant     = i_reset_n ? gnt_oh : '0;
    o_drop      = i_reset_n && drop;
    o_req_ready = i_reset_n ? ((gnt_oh & {N_REQ{a_ready}}) | drop_oh) : '0;

    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    if (state_q == ARB_IDLE) begin
      if (pick.found) begin
        if (acc && a_eop) begin
          ptr_d = inc_wrap(pick.idx);
        end else begin
          state_d = ARB_LOCKED;
          owner_d = pick.idx;
        end
      end
    end else if (acc && a_eop) begin
      state_d = ARB_IDLE;
      ptr_d   = inc_wrap(owner_q);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

`ifdef NAP_DS_ARB_OUTREG_EN
  nap_ds_skid_buf #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_skid (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_valid   (a_valid),
    .i_sop     (a_sop),
    .i_eop     (a_eop),
    .i_data    (a_data),
    .i_addr    (a_addr),
    .o_ready   (a_ready),
    .o_valid   (if_ds_tx.valid),
    .o_sop     (if_ds_tx.sop),
    .o_eop     (if_ds_tx.eop),
    .o_data    (if_ds_tx.data),
    .o_addr    (if_ds_tx.addr),
    .i_ready   (if_ds_tx.ready)
  );
`else
  assign a_ready        = if_ds_tx.ready;
  assign if_ds_tx.valid = i_reset_n && a_valid;
  assign if_ds_tx.sop   = i_reset_n && a_sop;
  assign if_ds_tx.eop   = i_reset_n && a_eop;
  assign if_ds_tx.data  = a_data;
  assign if_ds_tx.addr  = a_addr;
`endif
endmodule

// File: doc/nap_ds_tx_arbiter.md
# nap_ds_tx_arbiter

Packet-aware round-robin arbiter that shares one horizontal-NAP transmit data stream among `N_REQ` user-side requesters. It sits between the user logic and the NAP wrapper's transmit stream (`t_DATA_STREAM`). It grants one requester at a time on a start-of-packet beat and holds the grant until that packet's end-of-packet beat is accepted. Destination address, data, SOP and EOP are forwarded unchanged.

## Interface
- `N_REQ`, 4, number of requesters; legal range 2..8.
- `DATA_WIDTH`, 256, data bits per beat; must equal the `t_DATA_STREAM` data width.
- `ADDR_WIDTH`, 4, destination address bits; must equal the `t_DATA_STREAM` addr width.

- `i_clk`  in  1  single clock for the whole block.
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `i_req_valid`  in  N_REQ  per-requester beat valid.
- `i_req_sop`  in  N_REQ  per-requester start of packet.
- `i_req_eop`  in  N_REQ  per-requester end of packet.
- `i_req_data`  in  N_REQ*DATA_WIDTH  requester r occupies slice [r*DATA_WIDTH +: DATA_WIDTH].
- `i_req_addr`  in  N_REQ*ADDR_WIDTH  per-requester NoC destination.
- `o_req_ready`  out  N_REQ  per-requester beat accept.
- `if_ds_tx`  t_DATA_STREAM.tx  —  stream to the NAP wrapper's transmit port (valid/sop/eop/data/addr out, ready in).
- `o_grant`  out  N_REQ  one-hot current owner; all-zero when no requester is selected.
- `o_drop`  out  1  one-cycle pulse when a stray non-SOP beat is discarded.

## Operation
- State machine with two states.
  - **IDLE**: arbitrating.
  - **LOCKED**: an owner holds the stream.
- Reset values: state IDLE, RR pointer 0, `o_req_ready`=0, `if_ds_tx.valid`=0, `o_grant`=0, `o_drop`=0.
- **IDLE behaviour**
  - Requester r is eligible when `i_req_valid[r] & i_req_sop[r]`.
  - The winner is the first eligible requester searching upward from the pointer, with wrap at N_REQ-1 to 0.
  - The winner is granted combinationally in the same cycle. No bubble.
  - Winner's beat is accepted and has EOP (single-beat packet): stay IDLE, pointer = winner+1 mod N_REQ.
  - Otherwise (beat not accepted, or accepted without EOP): go to LOCKED with owner = winner. The grant is held so the output beat stays stable while ready is low.
- **LOCKED behaviour**
  - Only the owner is forwarded.
  - `o_req_ready[owner]` = `if_ds_tx.ready`. All other ready bits are 0.
  - On an accepted EOP beat: go to IDLE, pointer = owner+1 mod N_REQ.
  - SOP on the owner mid-packet is forwarded unchanged. No checking is done.
- **Stray beats**
  - In IDLE, when no requester is eligible, the lowest-index requester with valid & !sop gets ready=1 for one cycle.
  - Its beat is discarded and `o_drop` pulses.
  - Stray beats are never discarded in a cycle where a grant is made.
- **Non-owners**: ready is held 0 until a grant. Their valid/data may change freely.
- **Async reset mid-packet**: immediate return to reset values. The partial packet is abandoned and the NAP sees valid drop with no EOP.

## Timing
- Without `NAP_DS_ARB_OUTREG_EN`:
  - Zero-cycle data path from requester to `if_ds_tx`.
  - `o_req_ready` is combinational from `if_ds_tx.ready`.
- With `NAP_DS_ARB_OUTREG_EN`:
  - One cycle of latency.
  - `o_req_ready` comes from the skid buffer's registered ready.
- A back-to-back packet from a different requester is accepted in the cycle after the EOP handshake. No idle cycle.
- Fairness: any continuously eligible requester is granted within N_REQ-1 packets.

## Configuration
- `NAP_DS_ARB_OUTREG_EN` defined:
  - A 2-entry skid buffer sits between the arbiter and `if_ds_tx`.
  - It registers valid, sop, eop, data and addr.
  - It breaks the combinational ready path to the NAP.
  - Full throughput is kept; no bubbles when ready is continuously high.
  - The EOP handshake that releases LOCKED is the handshake at the arbiter side of the buffer.
- Undefined: no buffer; pure combinational mux as described in Operation.

## Structure
- Package `nap_ds_arb_pkg` holds:
  - state enum `arb_state_t` {ARB_IDLE, ARB_LOCKED};
  - `MAX_REQ` = 8;
  - the round-robin find-first function.
- Sub-module `nap_ds_skid_buf` (parameterised by DATA_WIDTH and ADDR_WIDTH) is instantiated only under `NAP_DS_ARB_OUTREG_EN`.

## Test plan
- **Single requester**: N_REQ=4; req1 sends a 3-beat packet, dest 4'h5, ready=1 → grant=0010 for 3 cycles; beats appear in order with sop on beat 0, eop on beat 2, addr 5; pointer=2.
- **Round-robin**: all four requesters send back-to-back 2-beat packets continuously, pointer=0 → grant order 0,1,2,3,0; no idle cycle between packets.
- **Backpressure**: req2 sends a 4-beat packet, `if_ds_tx.ready` low on cycles 1–3 → output beat held stable; req0 raises sop mid-packet and is not granted until after req2's EOP.
- **Single-beat packets**: req0 and req3 both send sop&eop beats every cycle → alternating grants 0,3,0,3 with one beat per cycle.
- **Stray beat**: req1 valid=1, sop=0 while IDLE and no eligible requester → ready[1]=1 for one cycle, `o_drop`=1 for one cycle, nothing on `if_ds_tx`.
- **Reset mid-packet**: assert `i_reset_n`=0 during beat 2 of a 5-beat packet → outputs 0 within the reset assertion; after release the pointer is 0 and a new sop from req3 is granted normally. Run with and without `NAP_DS_ARB_OUTREG_EN`.
